// File: rtl/cordic_arbiter_if.sv
// Two-channel request/response bundle around a shared CORDIC rotator.
// slave is the arbiter side, master is the requester/rotator side.
interface cordic_arbiter_if;
  logic       c0_req_valid;
  logic       c1_req_valid;
  logic       c0_req_ready;
  logic       c1_req_ready;
  logic [6:0] c0_req_angle;
  logic [6:0] c1_req_angle;
  logic [6:0] cor_z_tgt;
  logic [6:0] cor_x_in;
  logic [6:0] cor_y_in;
  logic       c0_rsp_valid;
  logic       c1_rsp_valid;
  logic       c0_rsp_ready;
  logic       c1_rsp_ready;
  logic [6:0] c0_rsp_x;
  logic [6:0] c0_rsp_y;
  logic [6:0] c1_rsp_x;
  logic [6:0] c1_rsp_y;
  logic       busy;

  modport slave (
    input  c0_req_valid, c1_req_valid,
    input  c0_req_angle, c1_req_angle,
    input  cor_x_in, cor_y_in,
    input  c0_rsp_ready, c1_rsp_ready,
    output c0_req_ready, c1_req_ready,
    output cor_z_tgt,
    output c0_rsp_valid, c1_rsp_valid,
    output c0_rsp_x, c0_rsp_y,
    output c1_rsp_x, c1_rsp_y,
    output busy
  );

  modport master (
    output c0_req_valid, c1_req_valid,
    output c0_req_angle, c1_req_angle,
    output cor_x_in, cor_y_in,
    output c0_rsp_ready, c1_rsp_ready,
    input  c0_req_ready, c1_req_ready,
    input  cor_z_tgt,
    input  c0_rsp_valid, c1_rsp_valid,
    input  c0_rsp_x, c0_rsp_y,
    input  c1_rsp_x, c1_rsp_y,
    input  busy
  );
endinterface

// File: rtl/cordic_arbiter.sv
// Round-robin sharing of one non-stallable CORDIC rotator between two
// channels, with credit-limited per-channel result FIFOs.
module cordic_arbiter #(
  parameter int PIPE_LAT = 6,
  parameter int DEPTH    = 4
) (
  input logic              clk,
  input logic              rst,
  cordic_arbiter_if.slave  io
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]       occ_q [2];
  logic [CW-1:0]       occ_d [2];
  logic [CW-1:0]       cnt_q [2];
  logic [CW-1:0]       cnt_d [2];
  logic [PW-1:0]       rd_q  [2];
  logic [PW-1:0]       rd_d  [2];
  logic [PW-1:0]       wr_q  [2];
  logic [PW-1:0]       wr_d  [2];
  logic [13:0]         mem_q [2][DEPTH];
  logic [13:0]         mem_d [2][DEPTH];
  logic [PIPE_LAT-1:0] tag_v_q, tag_v_d;
  logic [PIPE_LAT-1:0] tag_c_q, tag_c_d;
  logic                ptr_q, ptr_d;

  logic [1:0]  req_v, rsp_r, elig, gnt;
  logic [1:0]  nonempty, push, pop;
  logic [13:0] head [2];
  logic        issue, gch;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    req_v = {io.c1_req_valid, io.c0_req_valid};
    rsp_r = {io.c1_rsp_ready, io.c0_rsp_ready};
    for (int c = 0; c < 2; c++)
      elig[c] = req_v[c] && (occ_q[c] < CW'(DEPTH));

    // ptr_q holds the last granted channel; the other one wins a tie
    gnt = '0;
    if (!rst) begin
      unique case (elig)
        2'b11:   gnt = ptr_q ? 2'b01 : 2'b10;
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        default: gnt = '0;
      endcase
    end
    issue = |gnt;
    gch   = gnt[1];
    ptr_d = issue ? gch : ptr_q;

    tag_v_d = tag_v_q;
    tag_c_d = tag_c_q;
    tag_v_d[0] = issue;
    tag_c_d[0] = gch;
    for (int i = 1; i < PIPE_LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_c_d[i] = tag_c_q[i-1];
    end

    mem_d = mem_q;
    for (int c = 0; c < 2; c++) begin
      nonempty[c] = !rst && (cnt_q[c] != '0);
      pop[c]  = nonempty[c] && rsp_r[c];
      push[c] = tag_v_q[PIPE_LAT-1] &&
                (tag_c_q[PIPE_LAT-1] == 1'(c));
      head[c] = nonempty[c] ? mem_q[c][rd_q[c]] : '0;
      occ_d[c] = occ_q[c]
               + CW'(issue && (gch == 1'(c)))
               - CW'(pop[c]);
      cnt_d[c] = cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
      rd_d[c]  = pop[c]  ? nxt(rd_q[c]) : rd_q[c];
      wr_d[c]  = push[c] ? nxt(wr_q[c]) : wr_q[c];
      if (push[c])
        mem_d[c][wr_q[c]] = {io.cor_x_in, io.cor_y_in};
    end

    io.c0_req_ready = gnt[0];
    io.c1_req_ready = gnt[1];
    io.cor_z_tgt    = gnt[0] ? io.c0_req_angle :
                      gnt[1] ? io.c1_req_angle : 7'd0;
    io.c0_rsp_valid = nonempty[0];
    io.c1_rsp_valid = nonempty[1];
    io.c0_rsp_x     = head[0][13:7];
    io.c0_rsp_y     = head[0][6:0];
    io.c1_rsp_x     = head[1][13:7];
    io.c1_rsp_y     = head[1][6:0];
    io.busy         = !rst && ((|tag_v_q) || (|nonempty));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        occ_q[c] <= '0;
        cnt_q[c] <= '0;
        rd_q[c]  <= '0;
        wr_q[c]  <= '0;
      end
      tag_v_q <= '0;
      tag_c_q <= '0;
      ptr_q   <= 1'b1;
    end else begin
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      tag_v_q <= tag_v_d;
      tag_c_q <= tag_c_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage needs no reset; validity lives in the counters
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule
